// File: rtl/model_scalar_cosh_arbiter_pkg.sv
// Shared FSM state encoding and constants for the scalar cosh arbiter.
package model_scalar_cosh_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  // Wide enough for any DATA_SIZE in use; callers slice the low bits.
  localparam int                     MAX_DATA_SIZE = 1024;
  localparam logic [MAX_DATA_SIZE-1:0] ZERO_DATA   = '0;

endpackage

// File: rtl/model_scalar_rr_picker.sv
// Combinational round-robin pick: first pending index at or after rr_ptr, wrapping.
module model_scalar_rr_picker #(
  parameter int REQUESTERS = 4,
  parameter int IDX_W      = 2
) (
  input  logic [REQUESTERS-1:0] pending,
  input  logic [IDX_W-1:0]      rr_ptr,
  output logic [IDX_W-1:0]      grant,
  output logic                  grant_valid
);

  int               idx;
  logic [IDX_W-1:0] idx_w;

  // Scan offsets from the far end so the smallest offset from rr_ptr wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    idx_w       = '0;
    for (int off = REQUESTERS - 1; off >= 0; off--) begin
      idx = int'(rr_ptr) + off;
      if (idx >= REQUESTERS) begin
        idx = idx - REQUESTERS;
      end
      idx_w = IDX_W'(idx);
      if (pending[idx_w]) begin
        grant       = idx_w;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/model_scalar_cosh_arbiter.sv
// Round-robin arbiter sharing one scalar cosh unit among REQUESTERS ports.
// Optional WAIT watchdog enabled by MODEL_COSH_ARBITER_TIMEOUT_EN.
module model_scalar_cosh_arbiter
  import model_scalar_cosh_arbiter_pkg::*;
#(
  parameter int DATA_SIZE      = 64,
  parameter int REQUESTERS     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [REQUESTERS-1:0]           REQ_START,
  input  logic [REQUESTERS*DATA_SIZE-1:0] REQ_DATA_IN,
  output logic [REQUESTERS-1:0]           REQ_READY,
  output logic [DATA_SIZE-1:0]            REQ_DATA_OUT,
  output logic                            REQ_OVERFLOW_OUT,
  output logic                            FU_START,
  output logic [DATA_SIZE-1:0]            FU_DATA_IN,
  input  logic                            FU_READY,
  input  logic [DATA_SIZE-1:0]            FU_DATA_OUT,
  input  logic                            FU_OVERFLOW_OUT
);

  localparam int IDX_W = $clog2(REQUESTERS);
  localparam logic [DATA_SIZE-1:0] ZERO = ZERO_DATA[DATA_SIZE-1:0];

  arb_state_t                            state_q, state_d;
  logic [REQUESTERS-1:0]                 pending_q, pending_d;
  logic [REQUESTERS-1:0][DATA_SIZE-1:0]  buffer_q, buffer_d;
  logic [IDX_W-1:0]                      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]                      grant_q, grant_d;
  logic [REQUESTERS-1:0]                 ready_q, ready_d;
  logic [DATA_SIZE-1:0]                  data_out_q, data_out_d;
  logic                                  ovf_q, ovf_d;

  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_vld;
  logic                  complete;
  logic [DATA_SIZE-1:0]  cmp_data;
  logic                  cmp_ovf;
  logic [REQUESTERS-1:0] grant_oh;
  logic [REQUESTERS-1:0] clr;
  logic [REQUESTERS-1:0] accept;

`ifdef MODEL_COSH_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  model_scalar_rr_picker #(
    .REQUESTERS (REQUESTERS),
    .IDX_W      (IDX_W)
  ) u_picker (
    .pending     (pending_q),
    .rr_ptr      (rr_ptr_q),
    .grant       (pick_idx),
    .grant_valid (pick_vld)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    complete = 1'b0;
    cmp_data = data_out_q;
    cmp_ovf  = ovf_q;
`ifdef MODEL_COSH_ARBITER_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef MODEL_COSH_ARBITER_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      WAIT: begin
        // A unit response on the limit cycle beats the watchdog.
        if (FU_READY) begin
          complete = 1'b1;
          cmp_data = FU_DATA_OUT;
          cmp_ovf  = FU_OVERFLOW_OUT;
        end
`ifdef MODEL_COSH_ARBITER_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          complete = 1'b1;
          cmp_data = ZERO;
          cmp_ovf  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
        if (complete) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == IDX_W'(REQUESTERS - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A start on the completion edge of the same requester is accepted.
  always_comb begin
    grant_oh          = '0;
    grant_oh[grant_q] = 1'b1;
    clr               = complete ? grant_oh : '0;
    accept            = REQ_START & (~pending_q | clr);
    pending_d         = (pending_q & ~clr) | accept;
    buffer_d          = buffer_q;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (accept[i]) begin
        buffer_d[i] = REQ_DATA_IN[i*DATA_SIZE +: DATA_SIZE];
      end
    end
    ready_d    = clr;
    data_out_d = cmp_data;
    ovf_d      = cmp_ovf;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      buffer_q   <= '0;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      ready_q    <= '0;
      data_out_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      buffer_q   <= buffer_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      ready_q    <= ready_d;
      data_out_q <= data_out_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef MODEL_COSH_ARBITER_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  assign REQ_READY        = ready_q;
  assign REQ_DATA_OUT     = data_out_q;
  assign REQ_OVERFLOW_OUT = ovf_q;
  assign FU_START         = (state_q == ISSUE);
  assign FU_DATA_IN       = FU_START ? buffer_q[grant_q] : ZERO;

endmodule

// File: tb/tb_model_scalar_cosh_arbiter.sv
// Directed bench for model_scalar_cosh_arbiter with a fixed-latency XOR stub unit.
module tb_model_scalar_cosh_arbiter;

  localparam int DW = 64;
  localparam int NR = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NR-1:0]     REQ_START;
  logic [NR*DW-1:0]  REQ_DATA_IN;
  logic [NR-1:0]     REQ_READY;
  logic [DW-1:0]     REQ_DATA_OUT;
  logic              REQ_OVERFLOW_OUT;
  logic              FU_START;
  logic [DW-1:0]     FU_DATA_IN;
  logic              FU_READY;
  logic [DW-1:0]     FU_DATA_OUT;
  logic              FU_OVERFLOW_OUT;

  int checks = 0;
  int errors = 0;

  model_scalar_cosh_arbiter #(.DATA_SIZE(DW), .REQUESTERS(NR), .TIMEOUT_CYCLES(16)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .REQ_START        (REQ_START),
    .REQ_DATA_IN      (REQ_DATA_IN),
    .REQ_READY        (REQ_READY),
    .REQ_DATA_OUT     (REQ_DATA_OUT),
    .REQ_OVERFLOW_OUT (REQ_OVERFLOW_OUT),
    .FU_START         (FU_START),
    .FU_DATA_IN       (FU_DATA_IN),
    .FU_READY         (FU_READY),
    .FU_DATA_OUT      (FU_DATA_OUT),
    .FU_OVERFLOW_OUT  (FU_OVERFLOW_OUT)
  );

  always #5 CLK = ~CLK;

  // Stub unit: result = operand ^ 0xFF, overflow = operand sign bit, READY two cycles after START.
  logic          stub_mute;
  logic          s1;
  logic [DW-1:0] s_dat;
  always @(posedge CLK) begin
    s1 <= FU_START && !stub_mute;
    if (FU_START) s_dat <= FU_DATA_IN;
    FU_READY        <= s1;
    FU_DATA_OUT     <= s_dat ^ 64'h00000000000000FF;
    FU_OVERFLOW_OUT <= s_dat[63];
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [NR-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  typedef struct {
    int          idx;
    logic [63:0] din;
    logic [63:0] dout;
    logic        ovf;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nev;
    int          order[8];
    logic [63:0] odat[8];
    logic        oovf[8];
    int          multi;
    int          fs_cnt;
    int          rd_cnt;
    bit          inj;
    logic [63:0] exp_c_dat[4];

    vecs[0] = '{2, 64'h3FF0000000000000, 64'h3FF00000000000FF, 1'b0};
    vecs[1] = '{0, 64'h0000000000000000, 64'h00000000000000FF, 1'b0};
    vecs[2] = '{3, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFF00, 1'b1};
    vecs[3] = '{1, 64'h0123456789ABCDEF, 64'h0123456789ABCD10, 1'b0};
    vecs[4] = '{2, 64'hC000000000000055, 64'hC0000000000000AA, 1'b1};
    exp_c_dat = '{64'hFE, 64'hFD, 64'hFC, 64'hFB};

    RST = 1'b1;
    REQ_START = '0;
    REQ_DATA_IN = '0;
    stub_mute = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_ready", REQ_READY, '0);
    chk("rst_dout", REQ_DATA_OUT, '0);
    chk("rst_ovf", REQ_OVERFLOW_OUT, '0);
    chk("rst_fu_start", FU_START, '0);
    chk("rst_fu_din", FU_DATA_IN, '0);
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_fu_start", FU_START, '0);

    // Contention: all four start together, served 0..3 from rr_ptr=0.
    @(negedge CLK);
    REQ_START = 4'hF;
    for (int i = 0; i < NR; i++) REQ_DATA_IN[i*DW +: DW] = 64'(i + 1);
    nev = 0;
    multi = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      REQ_START = '0;
      if ($countones(REQ_READY) > 1) multi++;
      if (REQ_READY != '0 && nev < 8) begin
        order[nev] = oh_idx(REQ_READY);
        odat[nev]  = REQ_DATA_OUT;
        nev++;
      end
    end
    chk("cont_count", 64'(nev), 64'd4);
    chk("cont_onehot", 64'(multi), 64'd0);
    for (int e = 0; e < 4; e++) begin
      chk($sformatf("cont_order%0d", e), 64'(order[e]), 64'(e));
      chk($sformatf("cont_data%0d", e), odat[e], exp_c_dat[e]);
    end

    // Single-request table: FU_START two cycles and REQ_READY five cycles after the start.
    for (int v = 0; v < 5; v++) begin
      @(negedge CLK);
      REQ_START = '0;
      REQ_START[vecs[v].idx] = 1'b1;
      REQ_DATA_IN[vecs[v].idx*DW +: DW] = vecs[v].din;
      for (int k = 1; k <= 6; k++) begin
        @(negedge CLK);
        REQ_START = '0;
        chk($sformatf("v%0d_fu_start_k%0d", v, k), FU_START, (k == 2) ? 1 : 0);
        chk($sformatf("v%0d_ready_k%0d", v, k), REQ_READY,
            (k == 5) ? 64'(1 << vecs[v].idx) : 64'd0);
        if (k == 2) chk($sformatf("v%0d_fu_din", v), FU_DATA_IN, vecs[v].din);
        if (k >= 5) begin
          chk($sformatf("v%0d_dout_k%0d", v, k), REQ_DATA_OUT, vecs[v].dout);
          chk($sformatf("v%0d_ovf_k%0d", v, k), REQ_OVERFLOW_OUT, vecs[v].ovf);
        end
      end
    end

    // Re-request: duplicates while pending are dropped; a start on the completion edge is kept.
    nev = 0;
    inj = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (REQ_READY != '0 && nev < 8) begin
        order[nev] = oh_idx(REQ_READY);
        odat[nev]  = REQ_DATA_OUT;
        nev++;
      end
      REQ_START = '0;
      if (c == 0) begin
        REQ_START[1] = 1'b1;
        REQ_DATA_IN[1*DW +: DW] = 64'h1111000000000000;
      end else if (c <= 3) begin
        REQ_START[1] = 1'b1;
        REQ_DATA_IN[1*DW +: DW] = 64'h2222000000000000;
      end else if (FU_READY && !inj) begin
        REQ_START[1] = 1'b1;
        REQ_DATA_IN[1*DW +: DW] = 64'h3333000000000000;
        inj = 1'b1;
      end
    end
    chk("rereq_count", 64'(nev), 64'd2);
    chk("rereq_idx0", 64'(order[0]), 64'd1);
    chk("rereq_dat0", odat[0], 64'h11110000000000FF);
    chk("rereq_idx1", 64'(order[1]), 64'd1);
    chk("rereq_dat1", odat[1], 64'h33330000000000FF);

    // Reset one cycle after FU_START aborts the operation.
    @(negedge CLK);
    REQ_START = 4'b1000;
    REQ_DATA_IN[3*DW +: DW] = 64'h4000000000000000;
    @(negedge CLK);
    REQ_START = '0;
    @(negedge CLK);
    chk("rw_fu_start", FU_START, 1);
    @(negedge CLK);
    RST = 1'b1;
    REQ_START = 4'b0001;
    #1;
    chk("rw_ready", REQ_READY, '0);
    chk("rw_dout", REQ_DATA_OUT, '0);
    chk("rw_ovf", REQ_OVERFLOW_OUT, '0);
    chk("rw_fu_start0", FU_START, '0);
    chk("rw_fu_din", FU_DATA_IN, '0);
    @(negedge CLK);
    RST = 1'b0;
    REQ_START = '0;
    fs_cnt = 0;
    rd_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (FU_START) fs_cnt++;
      if (REQ_READY != '0) rd_cnt++;
    end
    chk("rw_no_ready", 64'(rd_cnt), 64'd0);
    chk("rw_no_issue", 64'(fs_cnt), 64'd0);
    chk("rw_dout_after", REQ_DATA_OUT, '0);

    // Silent unit.
    @(negedge CLK);
    stub_mute = 1'b1;
`ifdef MODEL_COSH_ARBITER_TIMEOUT_EN
    REQ_START = 4'b0011;
`else
    REQ_START = 4'b0001;
`endif
    REQ_DATA_IN[0 +: DW]  = 64'h5555000000000000;
    REQ_DATA_IN[DW +: DW] = 64'h6666000000000000;
    fs_cnt = 0;
    nev = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      REQ_START = '0;
      if (FU_START) fs_cnt++;
      if (REQ_READY != '0 && nev < 8) begin
        order[nev] = oh_idx(REQ_READY);
        odat[nev]  = REQ_DATA_OUT;
        oovf[nev]  = REQ_OVERFLOW_OUT;
        nev++;
      end
    end
`ifdef MODEL_COSH_ARBITER_TIMEOUT_EN
    chk("to_count", 64'(nev), 64'd2);
    chk("to_issues", 64'(fs_cnt), 64'd2);
    chk("to_idx0", 64'(order[0]), 64'd0);
    chk("to_dat0", odat[0], 64'd0);
    chk("to_ovf0", 64'(oovf[0]), 64'd1);
    chk("to_idx1", 64'(order[1]), 64'd1);
    chk("to_dat1", odat[1], 64'd0);
    chk("to_ovf1", 64'(oovf[1]), 64'd1);
`else
    chk("silent_no_ready", 64'(nev), 64'd0);
    chk("silent_one_issue", 64'(fs_cnt), 64'd1);
    chk("silent_fu_start_low", FU_START, '0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
